// File: rtl/floating_control_unit_if.sv
// Handshake and datapath-control bundle between the floating-point control unit
// and its environment (requester plus small/big ALU, shifter, rounding stage).
interface floating_control_unit_if #(
    parameter int EXPONENT = 8
);
    logic                start;
    logic [1:0]          op;
    logic [EXPONENT-1:0] expDiff;
    logic                roundOverflow;
    logic                smallerExpSrc;
    logic [EXPONENT-1:0] shiftRightQtt;
    logic [1:0]          operation;
    logic                normalization_src;
    logic                loadResult;
    logic                busy;
    logic                done;
    logic                error;

    modport master (
        output start, op, expDiff, roundOverflow,
        input  smallerExpSrc, shiftRightQtt, operation, normalization_src,
               loadResult, busy, done, error
    );

    modport slave (
        input  start, op, expDiff, roundOverflow,
        output smallerExpSrc, shiftRightQtt, operation, normalization_src,
               loadResult, busy, done, error
    );
endinterface

// File: rtl/floating_control_unit.sv
// Sequencer for a floating-point add/sub/mult datapath: exponent alignment,
// big-ALU execution, normalization with bounded post-rounding re-passes.
module floating_control_unit #(
    parameter int EXPONENT   = 8,
    parameter int MAX_RENORM = 1
) (
    input logic                     clk,
    input logic                     reset,
    floating_control_unit_if.slave  bus
);
    localparam int CW = (MAX_RENORM > 0) ? $clog2(MAX_RENORM + 1) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RENORM);

    typedef enum logic [2:0] {IDLE, ALIGN, EXEC, NORM, ROUND, FINISH} stateT;

    stateT         state;
    logic [1:0]    opReg;
    logic [CW-1:0] renormCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            opReg                 <= '0;
            renormCnt             <= '0;
            bus.smallerExpSrc     <= 1'b0;
            bus.shiftRightQtt     <= '0;
            bus.operation         <= '0;
            bus.normalization_src <= 1'b0;
            bus.busy              <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        opReg     <= bus.op;
                        renormCnt <= '0;
                        bus.busy  <= 1'b1;
                        state     <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (opReg == 2'b11) begin
                        state <= FINISH;
                    end else begin
                        if (opReg == 2'b10) begin
                            bus.smallerExpSrc <= 1'b0;
                            bus.shiftRightQtt <= '0;
                        end else begin
                            // Negating the most negative value wraps to itself, which
                            // read as unsigned is exactly its magnitude.
                            bus.smallerExpSrc <= bus.expDiff[EXPONENT-1];
                            bus.shiftRightQtt <= bus.expDiff[EXPONENT-1] ? -bus.expDiff
                                                                         : bus.expDiff;
                        end
                        bus.operation <= opReg;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    bus.operation         <= '0;
                    bus.normalization_src <= 1'b0;
                    state                 <= NORM;
                end
                NORM: begin
                    bus.normalization_src <= 1'b0;
                    state                 <= ROUND;
                end
                ROUND: begin
                    if (bus.roundOverflow && (renormCnt < MAX_CNT)) begin
                        renormCnt             <= renormCnt + CW'(1);
                        bus.normalization_src <= 1'b1;
                        state                 <= NORM;
                    end else begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    bus.smallerExpSrc <= 1'b0;
                    bus.shiftRightQtt <= '0;
                    bus.busy          <= 1'b0;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.done       = (state == FINISH);
    assign bus.error      = (state == FINISH) && (opReg == 2'b11);
    assign bus.loadResult = (state == FINISH) && (opReg != 2'b11);

endmodule
